condlogic: RTL and testbench
============================

# condlogic

Conditional-execution stage of the multicycle ARM core. Sits directly downstream of the instruction decoder and consumes its FSM and ALU-decoder outputs (PCS, NextPC, RegW, MemW, FlagW). It also consumes the instruction condition field and the ALU flags. It owns the architectural NZCV flag register and gates the raw decoder write requests into the final PCWrite, RegWrite and MemWrite strobes seen by the datapath and memory.

## Interface
Parameters:
- CNT_W, 16, width of the suppressed-commit counter (used only when the macro in Configuration is defined).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Cond  in  4  Instr[31:28], condition field of the current instruction.
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle.
- FlagW  in  2  decoder flag-write request; [1] = NZ, [0] = CV.
- PCS  in  1  decoder PC-source request (branch or write to R15).
- NextPC  in  1  unconditional PC advance (fetch state).
- RegW  in  1  decoder register-write request.
- MemW  in  1  decoder memory-write request.
- PCWrite  out  1  final PC write enable.
- RegWrite  out  1  final register-file write enable.
- MemWrite  out  1  final memory write enable.
- Flags  out  4  current architectural {N,Z,C,V}, for debug/trace.
- SquashCnt  out  CNT_W  suppressed-commit count (macro-dependent, see Configuration).

## Operation
- Flags register, 4 bits, split into two independently enabled halves:
  - FlagWrite[1] = FlagW[1] & CondEx loads Flags[3:2] <= ALUFlags[3:2].
  - FlagWrite[0] = FlagW[0] & CondEx loads Flags[1:0] <= ALUFlags[1:0].
- CondEx is combinational from Cond and the registered Flags (never ALUFlags):
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 MI: N.
  - 0101 PL: !N.
  - 0110 VS: V.
  - 0111 VC: !V.
  - 1000 HI: C&!Z.
  - 1001 LS: !C|Z.
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V).
  - 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: 0. Reserved; the instruction never executes.
- CondExDelayed: 1-bit register, loads CondEx every cycle.
- Output gating:
  - PCWrite = (PCS & CondExDelayed) | NextPC.
  - RegWrite = RegW & CondExDelayed.
  - MemWrite = MemW & CondExDelayed.
- NextPC is never gated, so fetch always advances the PC.
- All outputs are combinational from registers and current inputs. No output is registered.

## Timing
- Reset (synchronous): Flags = 4'b0000, CondExDelayed = 0, SquashCnt = 0. During and right after reset: RegWrite = MemWrite = 0, PCWrite = NextPC.
- Flag update is visible on Flags and in CondEx the cycle after the FlagW cycle. This is 1-cycle latency.
- Gating latency: write strobes use the CondEx value from the previous cycle. An instruction's writeback-state write is decided by flags as they stood during its execute state.
- Simultaneous FlagW and RegW in one cycle: RegWrite uses CondExDelayed, which is not affected by the same-edge flag update.
- An instruction whose condition fails does not modify flags, even with the S bit set.
- Reset asserted mid-instruction: state clears on that edge, and any pending RegW/MemW is suppressed on the following cycle.
- Cond or Flags changing mid-instruction only affects strobes from the following cycle.

## Configuration
- COND_SQUASH_CNT_EN defined:
  - SquashCnt is a CNT_W-bit counter.
  - It increments by 1 on each cycle where (PCS|RegW|MemW) & !CondExDelayed.
  - It saturates at all-ones.
  - PCS and RegW together in one cycle count once.
  - Reset clears it to 0.
- Not defined: SquashCnt is tied to 0, and no counter flops are synthesized.

## Test plan
- Reset: hold reset 2 cycles with RegW=MemW=PCS=1, NextPC=0 -> Flags=0000, RegWrite=MemWrite=PCWrite=0, SquashCnt=0.
- Flag split:
  - Step 1: Cond=1110, FlagW=10, ALUFlags=1111 -> next cycle Flags=1100.
  - Step 2: FlagW=01, ALUFlags=0000 -> next cycle Flags=1100.
  - Step 3: FlagW=01, ALUFlags=0011 -> next cycle Flags=1111.
- Condition sweep: for each Flags value 0000..1111 and Cond 0000..1111, RegW=1 -> RegWrite one cycle later equals the condition table, and is always 0 for Cond=1111.
- Squashed S-instruction: Flags=0100 (Z=1), Cond=0001 (NE), FlagW=11, ALUFlags=1000 -> Flags stays 0100; next-cycle RegW=1 gives RegWrite=0.
- Branch/fetch: Cond=0000 with Z=1, PCS=1 -> PCWrite=1. Same with Z=0 and NextPC=0 -> PCWrite=0. NextPC=1 with Cond=1111 -> PCWrite=1.
- Counter (macro defined, CNT_W=4):
  - 20 failing cycles with RegW=PCS=1 -> SquashCnt saturates at 15.
  - Passing-condition cycles leave it unchanged.
  - Reset returns it to 0.

Source files
------------

// File: rtl/condlogic.sv
// condlogic -- conditional-execution stage of the multicycle ARM core.
//
// Holds the architectural NZCV flags and gates the decoder's raw write
// requests (PCS, RegW, MemW) with the condition result. That result is
// evaluated against the registered flags and delayed one cycle, so a
// writeback-state write follows the flags as they stood during execute.
//
// Optional feature, selected with the COND_SQUASH_CNT_EN macro:
//   defined   - SquashCnt is a saturating count of cycles where a write
//               request was suppressed by a failed condition.
//   undefined - SquashCnt is tied to zero and no counter flops exist.
//
// No FSM and no handshake: every input is sampled every cycle.

module condlogic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] SquashCnt
);

    logic [3:0] flags_q;
    logic       cond_ex;
    logic       cond_ex_delayed;
    logic [1:0] flag_write;

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition check against the registered flags (never the live ALU flags).
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0; // 1111 is reserved: never executes
        endcase
    end

    // A failed condition also blocks the flag update, even with S set.
    assign flag_write = FlagW & {2{cond_ex}};

    // Flag register: NZ and CV halves load independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            if (flag_write[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (flag_write[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // Condition result carried into the next (writeback) cycle.
    always_ff @(posedge clk) begin
        if (reset) cond_ex_delayed <= 1'b0;
        else       cond_ex_delayed <= cond_ex;
    end

    // NextPC bypasses the gate so fetch always advances the PC.
    assign PCWrite  = (PCS & cond_ex_delayed) | NextPC;
    assign RegWrite = RegW & cond_ex_delayed;
    assign MemWrite = MemW & cond_ex_delayed;
    assign Flags    = flags_q;

`ifdef COND_SQUASH_CNT_EN
    logic [CNT_W-1:0] squash_cnt_q;
    logic             squash_hit;

    // Several requests in the same cycle still count as a single squash.
    assign squash_hit = (PCS | RegW | MemW) & ~cond_ex_delayed;

    // Saturating squash counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            squash_cnt_q <= '0;
        end else if (squash_hit && (squash_cnt_q != {CNT_W{1'b1}})) begin
            squash_cnt_q <= squash_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign SquashCnt = squash_cnt_q;
`else
    assign SquashCnt = '0;
`endif

endmodule

// File: tb/tb_condlogic.sv
// tb_condlogic -- directed self-checking bench for condlogic.
// Inputs change 1 time unit after a rising edge; outputs are checked
// a further time unit later, well away from the next edge.

module tb_condlogic;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] SquashCnt;

    int n_tests;
    int n_fail;

    condlogic #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .SquashCnt(SquashCnt)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        Cond     = 4'b1110;
        ALUFlags = 4'b0000;
        FlagW    = 2'b00;
        PCS      = 1'b0;
        NextPC   = 1'b0;
        RegW     = 1'b0;
        MemW     = 1'b0;
    endtask

    // Load all four flags through an always-executing instruction.
    task automatic load_flags(input logic [3:0] f);
        idle_inputs();
        Cond     = 4'b1110;
        FlagW    = 2'b11;
        ALUFlags = f;
        tick();
        FlagW    = 2'b00;
    endtask

    // Reference condition table, {N,Z,C,V}.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset: held two cycles with write requests asserted
        idle_inputs();
        reset = 1'b1;
        RegW  = 1'b1;
        MemW  = 1'b1;
        PCS   = 1'b1;
        tick();
        tick();
        check_eq("rst_flags", Flags, 4'b0000);
        check_eq("rst_regwrite", RegWrite, 1'b0);
        check_eq("rst_memwrite", MemWrite, 1'b0);
        check_eq("rst_pcwrite", PCWrite, 1'b0);
        check_eq("rst_squash", SquashCnt, 0);
        NextPC = 1'b1;
        settle();
        check_eq("rst_pcwrite_nextpc", PCWrite, 1'b1);
        reset = 1'b0;
        idle_inputs();
        tick();

        // Flag split: NZ and CV halves load independently
        Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1111;
        tick();
        check_eq("split_nz", Flags, 4'b1100);
        FlagW = 2'b01; ALUFlags = 4'b0000;
        tick();
        check_eq("split_cv_zero", Flags, 4'b1100);
        FlagW = 2'b01; ALUFlags = 4'b0011;
        tick();
        check_eq("split_cv_one", Flags, 4'b1111);
        FlagW = 2'b00;

        // Condition sweep: every Flags x Cond pair, strobes one cycle later
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                load_flags(4'(f));
                Cond = 4'(c);
                RegW = 1'b1;
                MemW = 1'b1;
                tick();
                check_eq($sformatf("sweep_reg_f%0h_c%0h", f, c), RegWrite,
                         cond_model(4'(c), 4'(f)));
                check_eq($sformatf("sweep_mem_f%0h_c%0h", f, c), MemWrite,
                         cond_model(4'(c), 4'(f)));
                check_eq($sformatf("sweep_flags_f%0h_c%0h", f, c), Flags, f);
                RegW = 1'b0;
                MemW = 1'b0;
            end
        end

        // Squashed S-instruction leaves flags and blocks the following write
        load_flags(4'b0100);
        Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b1000;
        tick();
        check_eq("squash_flags", Flags, 4'b0100);
        FlagW = 2'b00; RegW = 1'b1;
        settle();
        check_eq("squash_regwrite", RegWrite, 1'b0);
        RegW = 1'b0;

        // Same-cycle FlagW and RegW: strobe uses the pre-update condition
        load_flags(4'b0000);
        Cond = 4'b0000;
        tick();
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1'b1;
        settle();
        check_eq("same_cycle_regwrite", RegWrite, 1'b0);
        tick();
        check_eq("same_cycle_flags", Flags, 4'b0100);
        FlagW = 2'b00;
        settle();
        check_eq("same_cycle_next_regwrite", RegWrite, 1'b1);
        RegW = 1'b0;

        // Branch / fetch
        load_flags(4'b0100);
        Cond = 4'b0000;
        tick();
        PCS = 1'b1; NextPC = 1'b0;
        settle();
        check_eq("branch_taken", PCWrite, 1'b1);
        PCS = 1'b0;
        load_flags(4'b0000);
        Cond = 4'b0000;
        tick();
        PCS = 1'b1; NextPC = 1'b0;
        settle();
        check_eq("branch_not_taken", PCWrite, 1'b0);
        PCS = 1'b0; NextPC = 1'b1; Cond = 4'b1111; RegW = 1'b1;
        tick();
        check_eq("fetch_nextpc", PCWrite, 1'b1);
        check_eq("fetch_never_regwrite", RegWrite, 1'b0);
        idle_inputs();

        // Reset mid-instruction suppresses the pending write
        Cond = 4'b1110;
        tick();
        RegW = 1'b1; MemW = 1'b1;
        settle();
        check_eq("pre_reset_regwrite", RegWrite, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check_eq("post_reset_regwrite", RegWrite, 1'b0);
        check_eq("post_reset_memwrite", MemWrite, 1'b0);
        idle_inputs();

        // Squash counter (tied to zero when the feature is not built)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        Cond = 4'b0000; RegW = 1'b1; PCS = 1'b1;
        for (int i = 0; i < 5; i++) tick();
`ifdef COND_SQUASH_CNT_EN
        check_eq("cnt_five", SquashCnt, 5);
`else
        check_eq("cnt_five", SquashCnt, 0);
`endif
        RegW = 1'b0; PCS = 1'b0; Cond = 4'b1110;
        tick();
        RegW = 1'b1; PCS = 1'b1;
        for (int i = 0; i < 4; i++) tick();
`ifdef COND_SQUASH_CNT_EN
        check_eq("cnt_pass_hold", SquashCnt, 5);
`else
        check_eq("cnt_pass_hold", SquashCnt, 0);
`endif
        Cond = 4'b0000;
        for (int i = 0; i < 20; i++) tick();
`ifdef COND_SQUASH_CNT_EN
        check_eq("cnt_saturate", SquashCnt, 15);
`else
        check_eq("cnt_saturate", SquashCnt, 0);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("cnt_reset", SquashCnt, 0);
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
